// File: rtl/emg_channel_scheduler_if.sv
// emg_channel_scheduler_if: frame input bundle and EMG sample stream of the channel scheduler
//   i_frame_tick  start-of-frame strobe
//   i_spk_cnt     packed per-channel spike counts, ch k at [k*(NN+1) +: NN+1]
//   i_ch_enable   per-channel enable mask, sampled with the tick
//   emg_out       filtered EMG sample, holds between valids
//   emg_ch        channel index of emg_out
//   emg_valid     one-cycle sample strobe
interface emg_channel_scheduler_if #(
    parameter int NN  = 8,
    parameter int NCH = 4,
    parameter int CW  = 2
);
    logic                    i_frame_tick;
    logic [NCH*(NN+1)-1:0]   i_spk_cnt;
    logic [NCH-1:0]          i_ch_enable;
    logic signed [17:0]      emg_out;
    logic [CW-1:0]           emg_ch;
    logic                    emg_valid;
    modport master (output i_frame_tick, i_spk_cnt, i_ch_enable, input emg_out, emg_ch, emg_valid);
    modport slave  (input i_frame_tick, i_spk_cnt, i_ch_enable, output emg_out, emg_ch, emg_valid);
endinterface

// File: rtl/emg_channel_scheduler.sv
// emg_channel_scheduler: time-multiplexes one EMG band-pass filter across NCH banked channels
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   bus            frame inputs and EMG sample stream (slave side)
//   i_clear_state  zero filter banks and overrun flag, honoured only when idle
//   o_busy         frame in progress
//   o_frame_done   one-cycle strobe after the last channel of a frame
//   o_overrun      sticky flag: a tick arrived while busy and was dropped
module emg_channel_scheduler #(
    parameter int NN  = 8,
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    emg_channel_scheduler_if.slave  bus,
    input  logic                    i_clear_state,
    output logic                    o_busy,
    output logic                    o_frame_done,
    output logic                    o_overrun
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_EMIT, S_DONE} state_t;
    state_t                  r_state, w_next;
    logic [NCH*(NN+1)-1:0]   r_cnt;
    logic [NCH-1:0]          r_mask;
    logic [CW-1:0]           r_ch;
    logic signed [35:0]      r_lp [NCH];
    logic signed [35:0]      r_hp [NCH];
    logic signed [17:0]      r_out;
    logic                    r_ovr;
    logic [CW-1:0]           w_first_ch, w_next_ch;
    logic                    w_first_any, w_next_any;
    logic signed [35:0]      w_stim, w_lp, w_hp;
    logic                    w_start, w_clear;

    assign w_clear = (r_state == S_IDLE) && i_clear_state;
    assign w_start = (r_state == S_IDLE) && !i_clear_state && bus.i_frame_tick;

    // Descending scan so the lowest qualifying index wins.
    always_comb begin
        w_first_ch  = '0;
        w_first_any = 1'b0;
        w_next_ch   = '0;
        w_next_any  = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (bus.i_ch_enable[k]) begin
                w_first_ch  = CW'(k);
                w_first_any = 1'b1;
            end
            if (r_mask[k] && k > int'(r_ch)) begin
                w_next_ch  = CW'(k);
                w_next_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_stim = 36'(r_cnt[r_ch*(NN+1) +: NN+1]) << 7;
        w_hp   = r_hp[r_ch] + (w_stim >>> 4) - (r_hp[r_ch] >>> 4);
        w_lp   = r_lp[r_ch] - (r_lp[r_ch] >>> 2) + (w_stim >>> 2);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_start ? (w_first_any ? S_CALC : S_DONE) : S_IDLE;
            S_CALC:  w_next = S_EMIT;
            S_EMIT:  w_next = w_next_any ? S_CALC : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_mask <= '0;
            r_ch   <= '0;
            r_out  <= '0;
            r_ovr  <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                r_lp[k] <= '0;
                r_hp[k] <= '0;
            end
        end else begin
            if (w_start) begin
                r_cnt  <= bus.i_spk_cnt;
                r_mask <= bus.i_ch_enable;
                r_ch   <= w_first_ch;
            end
            if (r_state == S_EMIT && w_next_any) r_ch <= w_next_ch;
            if (r_state == S_CALC) begin
                r_lp[r_ch] <= w_lp;
                r_hp[r_ch] <= w_hp;
                r_out      <= w_lp[17:0] - w_hp[17:0];
            end
            if (w_clear) begin
                for (int k = 0; k < NCH; k++) begin
                    r_lp[k] <= '0;
                    r_hp[k] <= '0;
                end
            end
            r_ovr <= w_clear ? 1'b0 : (r_ovr || (r_state != S_IDLE && bus.i_frame_tick));
        end
    end

    assign bus.emg_out    = r_out;
    assign bus.emg_ch     = r_ch;
    assign bus.emg_valid  = (r_state == S_EMIT);
    assign o_busy         = (r_state != S_IDLE);
    assign o_frame_done   = (r_state == S_DONE);
    assign o_overrun      = r_ovr;
endmodule
